// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source CDB arbiter with per-source FIFOs and round-robin pop
//
// Purpose: the ALU and the LSB each push {rob_idx, val} into a small private FIFO.
// A round-robin scheduler pops at most one entry per cycle onto a registered CDB broadcast.
// Ports:
//   clk, rst_in (async active-low), rdy_in (0 freezes all state), roll_back (flush)
//   alu_en/alu_rob_idx/alu_val -> alu_full   ALU push side and back-pressure
//   lsb_en/lsb_rob_idx/lsb_val -> lsb_full   LSB push side and back-pressure
//   cdb_en/cdb_rob_idx/cdb_val/cdb_src       registered broadcast (src 0=ALU, 1=LSB)
//   err_ovf                                  sticky push-while-full flag
module cdb_arbiter #(
  parameter int ROB_IDX_W  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 roll_back,
  input  logic                 alu_en,
  input  logic [ROB_IDX_W-1:0] alu_rob_idx,
  input  logic [DATA_W-1:0]    alu_val,
  output logic                 alu_full,
  input  logic                 lsb_en,
  input  logic [ROB_IDX_W-1:0] lsb_rob_idx,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 lsb_full,
  output logic                 cdb_en,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_src,
  output logic                 err_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_IDX_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic [ENT_W-1:0] alu_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] lsb_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0] lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             cdb_en_q, cdb_en_d, cdb_src_q, cdb_src_d, err_q, err_d;
  logic [ROB_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;

  logic alu_ne, lsb_ne, alu_push, lsb_push, pop_alu, pop_lsb;
  logic [ENT_W-1:0] pop_ent;

  // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
  assign alu_full = (alu_cnt_q == DEPTH_C);
  assign lsb_full = (lsb_cnt_q == DEPTH_C);
  assign alu_ne   = (alu_cnt_q != '0);
  assign lsb_ne   = (lsb_cnt_q != '0);

  // A flush swallows both pushes and the pop of its cycle.
  assign alu_push = alu_en && !alu_full && !roll_back;
  assign lsb_push = lsb_en && !lsb_full && !roll_back;

  // On contention the source that did not win last time is served.
  assign pop_alu = !roll_back && alu_ne && (!lsb_ne || last_grant_q == SRC_LSB);
  assign pop_lsb = !roll_back && lsb_ne && !pop_alu;
  assign pop_ent = pop_alu ? alu_mem_q[alu_rd_q] : lsb_mem_q[lsb_rd_q];

  always_comb begin
    alu_wr_d     = alu_wr_q + PTR_W'(alu_push);
    lsb_wr_d     = lsb_wr_q + PTR_W'(lsb_push);
    alu_rd_d     = alu_rd_q + PTR_W'(pop_alu);
    lsb_rd_d     = lsb_rd_q + PTR_W'(pop_lsb);
    alu_cnt_d    = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(pop_alu);
    lsb_cnt_d    = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(pop_lsb);
    last_grant_d = last_grant_q;
    cdb_en_d     = pop_alu || pop_lsb;
    cdb_tag_d    = cdb_tag_q;
    cdb_val_d    = cdb_val_q;
    cdb_src_d    = cdb_src_q;
    err_d        = err_q;
    if (roll_back) begin
      alu_wr_d     = '0;
      lsb_wr_d     = '0;
      alu_rd_d     = '0;
      lsb_rd_d     = '0;
      alu_cnt_d    = '0;
      lsb_cnt_d    = '0;
      last_grant_d = SRC_LSB;
    end else begin
      if ((alu_en && alu_full) || (lsb_en && lsb_full)) err_d = 1'b1;
      if (pop_alu || pop_lsb) begin
        last_grant_d = pop_lsb;
        cdb_src_d    = pop_lsb;
        cdb_tag_d    = pop_ent[ENT_W-1:DATA_W];
        cdb_val_d    = pop_ent[DATA_W-1:0];
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (rdy_in && alu_push) alu_mem_q[alu_wr_q] <= {alu_rob_idx, alu_val};
    if (rdy_in && lsb_push) lsb_mem_q[lsb_wr_q] <= {lsb_rob_idx, lsb_val};
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      alu_wr_q     <= '0;
      alu_rd_q     <= '0;
      lsb_wr_q     <= '0;
      lsb_rd_q     <= '0;
      alu_cnt_q    <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= SRC_LSB;
      cdb_en_q     <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= SRC_ALU;
      err_q        <= 1'b0;
    end else if (rdy_in) begin
      alu_wr_q     <= alu_wr_d;
      alu_rd_q     <= alu_rd_d;
      lsb_wr_q     <= lsb_wr_d;
      lsb_rd_q     <= lsb_rd_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_en_q     <= cdb_en_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_val_q    <= cdb_val_d;
      cdb_src_q    <= cdb_src_d;
      err_q        <= err_d;
    end
  end

  assign cdb_en      = cdb_en_q;
  assign cdb_rob_idx = cdb_tag_q;
  assign cdb_val     = cdb_val_q;
  assign cdb_src     = cdb_src_q;
  assign err_ovf     = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a queue-based reference model
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int DW = 32;
  localparam int D  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, rdy_in, roll_back;
  logic alu_en, lsb_en, alu_full, lsb_full;
  logic [RW-1:0] alu_rob_idx, lsb_rob_idx, cdb_rob_idx;
  logic [DW-1:0] alu_val, lsb_val, cdb_val;
  logic cdb_en, cdb_src, err_ovf;

  cdb_arbiter #(.ROB_IDX_W(RW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .alu_en(alu_en), .alu_rob_idx(alu_rob_idx), .alu_val(alu_val), .alu_full(alu_full),
    .lsb_en(lsb_en), .lsb_rob_idx(lsb_rob_idx), .lsb_val(lsb_val), .lsb_full(lsb_full),
    .cdb_en(cdb_en), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val), .cdb_src(cdb_src),
    .err_ovf(err_ovf)
  );

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [DW-1:0] val;
  } ent_t;

  // Reference model: one queue per producer, plus the expected broadcast registers.
  ent_t aq[$];
  ent_t lq[$];
  logic m_en, m_src, m_err, m_lg;
  logic [RW-1:0] m_tag;
  logic [DW-1:0] m_val;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_en = 0; m_src = 0; m_err = 0; m_lg = 1; m_tag = '0; m_val = '0;
  endtask

  // Applies one clock edge of the arbitration rules to the model using the current inputs.
  task automatic model_edge();
    bit pa, pl;
    ent_t e;
    if (!rdy_in) return;
    if (roll_back) begin
      aq.delete();
      lq.delete();
      m_en = 0;
      m_lg = 1;
      return;
    end
    pa = (aq.size() > 0) && (lq.size() == 0 || m_lg == 1'b1);
    pl = !pa && (lq.size() > 0);
    if (alu_en) begin
      if (aq.size() == D) m_err = 1;
      else begin e.idx = alu_rob_idx; e.val = alu_val; aq.push_back(e); end
    end
    if (lsb_en) begin
      if (lq.size() == D) m_err = 1;
      else begin e.idx = lsb_rob_idx; e.val = lsb_val; lq.push_back(e); end
    end
    if (pa) begin
      e = aq.pop_front();
      m_en = 1; m_tag = e.idx; m_val = e.val; m_src = 0; m_lg = 0;
    end else if (pl) begin
      e = lq.pop_front();
      m_en = 1; m_tag = e.idx; m_val = e.val; m_src = 1; m_lg = 1;
    end else begin
      m_en = 0;
    end
  endtask

  task automatic step(input logic ae, input logic [RW-1:0] ai, input logic [DW-1:0] av,
                      input logic le, input logic [RW-1:0] li, input logic [DW-1:0] lv,
                      input logic rdy, input logic rb);
    alu_en = ae; alu_rob_idx = ai; alu_val = av;
    lsb_en = le; lsb_rob_idx = li; lsb_val = lv;
    rdy_in = rdy; roll_back = rb;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0, 1, 0);
  endtask

  task automatic do_reset();
    rst_in = 0; rdy_in = 1; roll_back = 0;
    alu_en = 0; alu_rob_idx = '0; alu_val = '0;
    lsb_en = 0; lsb_rob_idx = '0; lsb_val = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_in = 1;
  endtask

  task automatic test_reset();
    // Dirty the state first so the asynchronous reset has something to clear.
    do_reset();
    step(1, 4'h7, 32'h77, 1, 4'h8, 32'h88, 1, 0);
    idle();
    #2;
    rst_in = 0;
    #1;
    n_chk++;
    if ({cdb_en, cdb_rob_idx, cdb_val, cdb_src, err_ovf, alu_full, lsb_full} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b tag=%h val=%h src=%b err=%b af=%b lf=%b, need all 0",
               cdb_en, cdb_rob_idx, cdb_val, cdb_src, err_ovf, alu_full, lsb_full);
    end
    do_reset();
    idle();
    n_chk++;
    if (cdb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_stale: cdb_en got %b need 0", cdb_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1, 4'd3, 32'h11, 0, '0, '0, 1, 0);
    n_chk++;
    if (cdb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: cdb_en got %b need 0 one edge after push", cdb_en);
    end
    idle();
    n_chk++;
    if ({cdb_en, cdb_rob_idx, cdb_val, cdb_src} !== {1'b1, 4'd3, 32'h11, 1'b0}) begin
      n_fail++;
      $display("FAIL single_bcast: got en=%b tag=%0d val=%h src=%b need 1/3/11/0",
               cdb_en, cdb_rob_idx, cdb_val, cdb_src);
    end
    idle();
    n_chk++;
    if ({cdb_en, cdb_rob_idx, cdb_val} !== {1'b0, 4'd3, 32'h11}) begin
      n_fail++;
      $display("FAIL single_once: got en=%b tag=%0d val=%h need 0/3/11 held",
               cdb_en, cdb_rob_idx, cdb_val);
    end
  endtask

  task automatic test_interleave();
    logic [RW-1:0] et [4];
    logic [DW-1:0] ev [4];
    logic          es [4];
    et = '{4'd1, 4'd5, 4'd2, 4'd6};
    ev = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    es = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    step(1, 4'd1, 32'hA0, 1, 4'd5, 32'hB0, 1, 0);
    step(1, 4'd2, 32'hA1, 1, 4'd6, 32'hB1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({cdb_en, cdb_rob_idx, cdb_val, cdb_src} !== {1'b1, et[k], ev[k], es[k]}) begin
        n_fail++;
        $display("FAIL interleave_%0d: got en=%b tag=%0d val=%h src=%b need 1/%0d/%h/%b",
                 k, cdb_en, cdb_rob_idx, cdb_val, cdb_src, et[k], ev[k], es[k]);
      end
      idle();
    end
    n_chk++;
    if (cdb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL interleave_drain: cdb_en got %b need 0", cdb_en);
    end
  endtask

  task automatic test_full();
    bit saw_full = 0;
    do_reset();
    // ALU pushes every cycle regardless of back-pressure; LSB respects it.
    for (int c = 0; c < 6; c++) begin
      step(1, RW'(c), DW'(32'h100 + c), (lq.size() != D), RW'(c + 8), DW'(32'h200 + c), 1, 0);
      n_chk++;
      if ({alu_full, lsb_full, err_ovf, cdb_en} !== {aq.size() == D, lq.size() == D, m_err, m_en}) begin
        n_fail++;
        $display("FAIL full_cyc%0d: got af=%b lf=%b err=%b en=%b need %b/%b/%b/%b", c,
                 alu_full, lsb_full, err_ovf, cdb_en, aq.size() == D, lq.size() == D, m_err, m_en);
      end
      if (alu_full) saw_full = 1;
    end
    n_chk++;
    if ({saw_full, err_ovf} !== 2'b11) begin
      n_fail++;
      $display("FAIL full_ovf: got saw_full=%b err=%b need 1/1", saw_full, err_ovf);
    end
    step(0, '0, '0, 0, '0, '0, 1, 1);
    n_chk++;
    if ({err_ovf, alu_full, lsb_full, cdb_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_after_rb: got err=%b af=%b lf=%b en=%b need 1/0/0/0",
               err_ovf, alu_full, lsb_full, cdb_en);
    end
  endtask

  task automatic test_rollback();
    do_reset();
    step(1, 4'd1, 32'h31, 1, 4'd9, 32'h39, 1, 0);
    step(1, 4'd2, 32'h32, 1, 4'd10, 32'h3A, 1, 0);
    step(1, 4'd3, 32'h33, 1, 4'd11, 32'h3B, 1, 1);
    n_chk++;
    if ({cdb_en, alu_full, lsb_full} !== 3'b000) begin
      n_fail++;
      $display("FAIL rb_flush: got en=%b af=%b lf=%b need 0/0/0", cdb_en, alu_full, lsb_full);
    end
    for (int c = 0; c < 3; c++) begin
      idle();
      n_chk++;
      if (cdb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rb_stale_%0d: cdb_en got %b tag=%0d need 0", c, cdb_en, cdb_rob_idx);
      end
    end
    // After the flush the ALU must win the first tie again.
    step(1, 4'd4, 32'h44, 1, 4'd12, 32'h4C, 1, 0);
    idle();
    n_chk++;
    if ({cdb_en, cdb_rob_idx, cdb_src} !== {1'b1, 4'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL rb_tie: got en=%b tag=%0d src=%b need 1/4/0", cdb_en, cdb_rob_idx, cdb_src);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    step(1, 4'd1, 32'h51, 1, 4'd5, 32'h55, 1, 0);
    step(1, 4'd2, 32'h52, 1, 4'd6, 32'h56, 1, 0);
    for (int c = 0; c < 9; c++) begin
      if (c >= 2 && c < 5)
        step(1, RW'($urandom), $urandom, 1, RW'($urandom), $urandom, 0, c == 3);
      else
        idle();
      n_chk++;
      if ({cdb_en, alu_full, lsb_full} !== {m_en, aq.size() == D, lq.size() == D} ||
          (m_en && {cdb_rob_idx, cdb_val, cdb_src} !== {m_tag, m_val, m_src})) begin
        n_fail++;
        $display("FAIL freeze_cyc%0d: got en=%b tag=%0d val=%h src=%b af=%b lf=%b need %b/%0d/%h/%b/%b/%b",
                 c, cdb_en, cdb_rob_idx, cdb_val, cdb_src, alu_full, lsb_full,
                 m_en, m_tag, m_val, m_src, aq.size() == D, lq.size() == D);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp_t[$];
    logic [RW-1:0] got_t[$];
    logic [DW-1:0] v;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        v = $urandom;
        exp_t.push_back(RW'(i));
        step(0, '0, '0, 1, RW'(i), v, 1, 0);
      end else begin
        idle();
      end
      n_chk++;
      if (cdb_en !== m_en || (m_en && {cdb_rob_idx, cdb_val, cdb_src} !== {m_tag, m_val, m_src})) begin
        n_fail++;
        $display("FAIL b2b_cyc%0d: got en=%b tag=%0d val=%h src=%b need %b/%0d/%h/%b",
                 i, cdb_en, cdb_rob_idx, cdb_val, cdb_src, m_en, m_tag, m_val, m_src);
      end
      if (cdb_en) got_t.push_back(cdb_rob_idx);
    end
    n_chk++;
    if (got_t.size() != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d broadcasts need 20", got_t.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_chk++;
        if (got_t[i] !== exp_t[i]) begin
          n_fail++;
          $display("FAIL b2b_order_%0d: got tag %0d need %0d", i, got_t[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ae, le, rdy, rb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 7) != 0);
      rb  = ($urandom_range(0, 39) == 0);
      ae  = ($urandom_range(0, 2) != 0) && (aq.size() != D || $urandom_range(0, 9) == 0);
      le  = ($urandom_range(0, 2) != 0) && (lq.size() != D || $urandom_range(0, 9) == 0);
      step(ae, RW'($urandom), $urandom, le, RW'($urandom), $urandom, rdy, rb);
      n_chk++;
      if ({cdb_en, alu_full, lsb_full, err_ovf} !== {m_en, aq.size() == D, lq.size() == D, m_err} ||
          (m_en && {cdb_rob_idx, cdb_val, cdb_src} !== {m_tag, m_val, m_src})) begin
        n_fail++;
        $display("FAIL rnd_cyc%0d: got en=%b tag=%0d val=%h src=%b af=%b lf=%b err=%b need %b/%0d/%h/%b/%b/%b/%b",
                 c, cdb_en, cdb_rob_idx, cdb_val, cdb_src, alu_full, lsb_full, err_ovf,
                 m_en, m_tag, m_val, m_src, aq.size() == D, lq.size() == D, m_err);
      end
    end
  endtask

  initial begin
    rst_in = 0; rdy_in = 1; roll_back = 0;
    alu_en = 0; alu_rob_idx = '0; alu_val = '0;
    lsb_en = 0; lsb_rob_idx = '0; lsb_val = '0;
    #1;
    test_reset();
    test_single();
    test_interleave();
    test_full();
    test_rollback();
    test_freeze();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
